// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the memory-stage sequencer.
package mem_access_ctrl_pkg;

  localparam int cDataWidth = 32;

  // Access size/sign encoding, shared by loads and stores.
  localparam logic [2:0] cLb  = 3'b000;
  localparam logic [2:0] cLh  = 3'b001;
  localparam logic [2:0] cLw  = 3'b010;
  localparam logic [2:0] cLbu = 3'b100;
  localparam logic [2:0] cLhu = 3'b101;

  typedef enum logic [1:0] {
    eIdle   = 2'd0,
    eReq    = 2'd1,
    eWaitRd = 2'd2
  } tMemState;

  typedef struct packed {
    logic                  dv;
    logic [4:0]            addr;
    logic [cDataWidth-1:0] data;
  } tRegOp;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [2:0]            opType;
    logic [cDataWidth-1:0] addr;
    logic [cDataWidth-1:0] data;
  } tMemOp;

  typedef struct packed {
    tMemOp memOp;
    tRegOp regOp;
  } tAluOut;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [cDataWidth-1:0] addr;
    logic [3:0]            be;
    logic [cDataWidth-1:0] wdata;
  } tMemReq;

  // Legal opcode whose natural alignment is met by the low address bits.
  function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      cLb, cLbu: op_aligned = 1'b1;
      cLh, cLhu: op_aligned = ~lane[0];
      cLw:       op_aligned = (lane == 2'b00);
      default:   op_aligned = 1'b0;
    endcase
  endfunction

  // Byte enables for the addressed lane(s).
  function automatic logic [3:0] lane_be(input logic [2:0] op, input logic [1:0] lane);
    case (op[1:0])
      2'b00:   lane_be = 4'b0001 << lane;
      2'b01:   lane_be = 4'b0011 << lane;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated so the addressed lane always carries the value.
  function automatic logic [cDataWidth-1:0] lane_wdata(input logic [2:0] op,
                                                       input logic [cDataWidth-1:0] d);
    case (op[1:0])
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/halfword of a load word and sign/zero-extends it.
module load_align_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [cDataWidth-1:0] iMemRData,
  input  logic [1:0]            iAddr,
  input  logic [2:0]            iOpType,
  output logic [cDataWidth-1:0] oData
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to the opcode.
  always_comb begin
    case (iAddr)
      2'd0:    byte_sel = iMemRData[7:0];
      2'd1:    byte_sel = iMemRData[15:8];
      2'd2:    byte_sel = iMemRData[23:16];
      default: byte_sel = iMemRData[31:24];
    endcase
    half_sel = iAddr[1] ? iMemRData[31:16] : iMemRData[15:0];
    case (iOpType)
      cLb:     oData = {{24{byte_sel[7]}}, byte_sel};
      cLbu:    oData = {24'h0, byte_sel};
      cLh:     oData = {{16{half_sel[15]}}, half_sel};
      cLhu:    oData = {16'h0, half_sel};
      default: oData = iMemRData;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: runs the data-memory req/gnt/rvalid handshake for
// loads and stores and merges load results with ALU writebacks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting ops; ALU-only ops written back, errors flagged
// REQ      | oMemReq held with stable address/data until iMemGnt
// WAIT_RD  | load granted, waiting for iMemRValid
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int cTimeoutW = 8
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iAluValid,
  input  tAluOut                iAluOut,
  output logic                  oStall,
  output logic                  oMemReq,
  output logic                  oMemWe,
  output logic [cDataWidth-1:0] oMemAddr,
  output logic [cDataWidth-1:0] oMemWData,
  output logic [3:0]            oMemBe,
  input  logic                  iMemGnt,
  input  logic                  iMemRValid,
  input  logic [cDataWidth-1:0] iMemRData,
  output tRegOp                 oRegOp,
  output logic                  oErr,
  output logic [cDataWidth-1:0] oErrAddr
);

  localparam logic [1:0] ST_IDLE    = eIdle;
  localparam logic [1:0] ST_REQ     = eReq;
  localparam logic [1:0] ST_WAIT_RD = eWaitRd;

  logic [1:0]            state_q, state_d;
  tMemReq                mreq_q, mreq_d;
  logic [cDataWidth-1:0] addr_q, addr_d;
  logic [2:0]            op_q, op_d;
  logic [4:0]            rd_q, rd_d;
  logic [cTimeoutW-1:0]  wd_q, wd_d;
  tRegOp                 reg_op_q, reg_op_d;
  logic                  err_q, err_d;
  logic [cDataWidth-1:0] err_addr_q, err_addr_d;

  logic [cDataWidth-1:0] load_data;
  logic [cTimeoutW-1:0]  wd_nxt;
  logic                  wd_expired;
  tMemOp                 mem_op;

  load_align_ext u_load_align_ext (
    .iMemRData (iMemRData),
    .iAddr     (addr_q[1:0]),
    .iOpType   (op_q),
    .oData     (load_data)
  );

  assign mem_op     = iAluOut.memOp;
  assign wd_nxt     = wd_q + 1'b1;
  assign wd_expired = (wd_nxt == {cTimeoutW{1'b1}});

  // Next-state, handshake and writeback decisions.
  always_comb begin
    state_d     = state_q;
    mreq_d      = mreq_q;
    addr_d      = addr_q;
    op_d        = op_q;
    rd_d        = rd_q;
    wd_d        = wd_q;
    reg_op_d    = reg_op_q;
    reg_op_d.dv = 1'b0;
    err_d       = 1'b0;
    err_addr_d  = err_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (iAluValid) begin
          if (!mem_op.read && !mem_op.write) begin
            // Address/data only move on a real writeback so they hold otherwise.
            if (iAluOut.regOp.dv) reg_op_d = iAluOut.regOp;
          end else if ((mem_op.read && mem_op.write) ||
                       !op_aligned(mem_op.opType, mem_op.addr[1:0])) begin
            err_d      = 1'b1;
            err_addr_d = mem_op.addr;
          end else begin
            mreq_d.req   = 1'b1;
            mreq_d.we    = mem_op.write;
            mreq_d.addr  = {mem_op.addr[cDataWidth-1:2], 2'b00};
            mreq_d.be    = lane_be(mem_op.opType, mem_op.addr[1:0]);
            mreq_d.wdata = mem_op.write ? lane_wdata(mem_op.opType, mem_op.data) : '0;
            addr_d       = mem_op.addr;
            op_d         = mem_op.opType;
            rd_d         = iAluOut.regOp.addr;
            wd_d         = '0;
            state_d      = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        wd_d = wd_nxt;
        if (iMemGnt) begin
          mreq_d.req = 1'b0;
          if (mreq_q.we) begin
            state_d = ST_IDLE;
          end else if (iMemRValid) begin
            // Zero-wait memory: data arrives with the grant.
            if (rd_q != 5'd0) begin
              reg_op_d.dv   = 1'b1;
              reg_op_d.addr = rd_q;
              reg_op_d.data = load_data;
            end
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RD;
          end
        end else if (wd_expired) begin
          mreq_d.req = 1'b0;
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = ST_IDLE;
        end
      end

      ST_WAIT_RD: begin
        wd_d = wd_nxt;
        if (iMemRValid) begin
          if (rd_q != 5'd0) begin
            reg_op_d.dv   = 1'b1;
            reg_op_d.addr = rd_q;
            reg_op_d.data = load_data;
          end
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      mreq_q     <= '0;
      addr_q     <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      wd_q       <= '0;
      reg_op_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mreq_q     <= mreq_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
      reg_op_q   <= reg_op_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign oStall    = (state_q != ST_IDLE);
  assign oMemReq   = mreq_q.req;
  assign oMemWe    = mreq_q.we;
  assign oMemAddr  = mreq_q.addr;
  assign oMemBe    = mreq_q.be;
  assign oMemWData = mreq_q.wdata;
  assign oRegOp    = reg_op_q;
  assign oErr      = err_q;
  assign oErrAddr  = err_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table-driven loads/stores/errors plus
// hand-written multi-cycle sequences.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iAluValid = 1'b0;
  tAluOut      iAluOut = '0;
  logic        oStall, oMemReq, oMemWe, oErr;
  logic [31:0] oMemAddr, oMemWData, oErrAddr;
  logic [3:0]  oMemBe;
  logic        iMemGnt = 1'b0;
  logic        iMemRValid = 1'b0;
  logic [31:0] iMemRData = '0;
  tRegOp       oRegOp;

  int n_chk = 0;
  int n_fail = 0;
  int dv_cnt = 0;
  int req_cnt = 0;

  mem_access_ctrl #(.cTimeoutW(8)) dut (
    .iClk(iClk), .iRst(iRst), .iAluValid(iAluValid), .iAluOut(iAluOut),
    .oStall(oStall), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .oMemBe(oMemBe), .iMemGnt(iMemGnt),
    .iMemRValid(iMemRValid), .iMemRData(iMemRData), .oRegOp(oRegOp),
    .oErr(oErr), .oErrAddr(oErrAddr)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    if (oRegOp.dv === 1'b1) dv_cnt++;
    if (oMemReq === 1'b1) req_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic present(input logic rd_en, input logic wr_en, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd);
    iAluOut               = '0;
    iAluOut.memOp.read    = rd_en;
    iAluOut.memOp.write   = wr_en;
    iAluOut.memOp.opType  = op;
    iAluOut.memOp.addr    = addr;
    iAluOut.memOp.data    = data;
    iAluOut.regOp.addr    = rd;
    iAluValid             = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          gnt_delay;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } st_vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] rdata;
    bit          zero_wait;
    logic        exp_dv;
    logic [31:0] exp_data;
  } ld_vec_t;

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  op;
    logic [31:0] addr;
  } err_vec_t;

  st_vec_t  sv[4];
  ld_vec_t  lv[8];
  err_vec_t ev[4];

  initial begin
    int dv0, req0, cyc;

    sv[0] = '{cLb, 32'h0000_1003, 32'h0000_00AB, 2, 4'b1000, 32'hABAB_ABAB};
    sv[1] = '{cLh, 32'h0000_1002, 32'h1234_CDEF, 0, 4'b1100, 32'hCDEF_CDEF};
    sv[2] = '{cLw, 32'h0000_1004, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D};
    sv[3] = '{cLb, 32'h0000_1000, 32'h0000_0055, 0, 4'b0001, 32'h5555_5555};

    lv[0] = '{cLb,  32'h0000_2001, 5'd7, 32'h0000_8000, 1'b0, 1'b1, 32'hFFFF_FF80};
    lv[1] = '{cLbu, 32'h0000_2001, 5'd7, 32'h0000_8000, 1'b0, 1'b1, 32'h0000_0080};
    lv[2] = '{cLh,  32'h0000_2002, 5'd7, 32'h8001_0000, 1'b0, 1'b1, 32'hFFFF_8001};
    lv[3] = '{cLhu, 32'h0000_2002, 5'd8, 32'h8001_0000, 1'b0, 1'b1, 32'h0000_8001};
    lv[4] = '{cLw,  32'h0000_3000, 5'd9, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
    lv[5] = '{cLb,  32'h0000_2003, 5'd3, 32'h7F00_0000, 1'b0, 1'b1, 32'h0000_007F};
    lv[6] = '{cLh,  32'h0000_2000, 5'd4, 32'h0000_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFE};
    lv[7] = '{cLw,  32'h0000_3004, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 32'h0};

    ev[0] = '{1'b1, 1'b0, cLw,    32'h0000_4002};
    ev[1] = '{1'b0, 1'b1, cLh,    32'h0000_4001};
    ev[2] = '{1'b1, 1'b1, cLw,    32'h0000_5000};
    ev[3] = '{1'b1, 1'b0, 3'b011, 32'h0000_6000};

    // Reset state
    tick(); tick();
    iRst = 1'b0;
    check("rst_stall", 32'(oStall), 32'd0);
    check("rst_req",   32'(oMemReq), 32'd0);
    check("rst_addr",  oMemAddr, 32'd0);
    check("rst_regop", 32'(oRegOp), 32'd0);
    check("rst_err",   32'(oErr), 32'd0);

    // ALU-only pass-through, latency 1
    present(1'b0, 1'b0, cLb, 32'h0, 32'h0, 5'd5);
    iAluOut.regOp.dv   = 1'b1;
    iAluOut.regOp.data = 32'h0000_1234;
    tick();
    iAluValid = 1'b0;
    check("alu_dv",    32'(oRegOp.dv), 32'd1);
    check("alu_addr",  32'(oRegOp.addr), 32'd5);
    check("alu_data",  oRegOp.data, 32'h0000_1234);
    check("alu_stall", 32'(oStall), 32'd0);
    tick();
    check("alu_dv_pulse", 32'(oRegOp.dv), 32'd0);
    check("alu_data_hold", oRegOp.data, 32'h0000_1234);

    // Stores
    for (int i = 0; i < 4; i++) begin
      dv0 = dv_cnt;
      present(1'b0, 1'b1, sv[i].op, sv[i].addr, sv[i].data, 5'd0);
      tick();
      iAluValid = 1'b0;
      for (int k = 0; k <= sv[i].gnt_delay; k++) begin
        check($sformatf("st%0d_req", i),   32'(oMemReq), 32'd1);
        check($sformatf("st%0d_we", i),    32'(oMemWe), 32'd1);
        check($sformatf("st%0d_stall", i), 32'(oStall), 32'd1);
        check($sformatf("st%0d_addr", i),  oMemAddr, sv[i].addr & 32'hFFFF_FFFC);
        check($sformatf("st%0d_be", i),    32'(oMemBe), 32'(sv[i].exp_be));
        check($sformatf("st%0d_wdata", i), oMemWData, sv[i].exp_wdata);
        if (k == sv[i].gnt_delay) iMemGnt = 1'b1;
        tick();
      end
      iMemGnt = 1'b0;
      check($sformatf("st%0d_req_drop", i), 32'(oMemReq), 32'd0);
      check($sformatf("st%0d_stall_drop", i), 32'(oStall), 32'd0);
      tick();
      check($sformatf("st%0d_no_wb", i), 32'(dv_cnt - dv0), 32'd0);
    end

    // Loads
    for (int i = 0; i < 8; i++) begin
      present(1'b1, 1'b0, lv[i].op, lv[i].addr, 32'h0, lv[i].rd);
      tick();
      iAluValid = 1'b0;
      check($sformatf("ld%0d_req", i),  32'(oMemReq), 32'd1);
      check($sformatf("ld%0d_we", i),   32'(oMemWe), 32'd0);
      check($sformatf("ld%0d_addr", i), oMemAddr, lv[i].addr & 32'hFFFF_FFFC);
      iMemGnt = 1'b1;
      if (lv[i].zero_wait) begin
        iMemRValid = 1'b1;
        iMemRData  = lv[i].rdata;
      end
      tick();
      iMemGnt = 1'b0;
      iMemRValid = 1'b0;
      if (!lv[i].zero_wait) begin
        check($sformatf("ld%0d_req_drop", i), 32'(oMemReq), 32'd0);
        check($sformatf("ld%0d_wait_stall", i), 32'(oStall), 32'd1);
        check($sformatf("ld%0d_wait_nodv", i), 32'(oRegOp.dv), 32'd0);
        tick();
        iMemRValid = 1'b1;
        iMemRData  = lv[i].rdata;
        tick();
        iMemRValid = 1'b0;
      end
      check($sformatf("ld%0d_dv", i),    32'(oRegOp.dv), 32'(lv[i].exp_dv));
      check($sformatf("ld%0d_stall", i), 32'(oStall), 32'd0);
      check($sformatf("ld%0d_reqoff", i), 32'(oMemReq), 32'd0);
      if (lv[i].exp_dv) begin
        check($sformatf("ld%0d_rd", i),   32'(oRegOp.addr), 32'(lv[i].rd));
        check($sformatf("ld%0d_data", i), oRegOp.data, lv[i].exp_data);
      end
      tick();
      check($sformatf("ld%0d_dv_pulse", i), 32'(oRegOp.dv), 32'd0);
    end

    // Error path: misaligned, read&write, illegal opcode
    for (int i = 0; i < 4; i++) begin
      dv0 = dv_cnt;
      req0 = req_cnt;
      present(ev[i].rd_en, ev[i].wr_en, ev[i].op, ev[i].addr, 32'h0, 5'd1);
      tick();
      iAluValid = 1'b0;
      check($sformatf("err%0d_pulse", i), 32'(oErr), 32'd1);
      check($sformatf("err%0d_addr", i),  oErrAddr, ev[i].addr);
      check($sformatf("err%0d_stall", i), 32'(oStall), 32'd0);
      tick();
      check($sformatf("err%0d_pulse_end", i), 32'(oErr), 32'd0);
      check($sformatf("err%0d_addr_hold", i), oErrAddr, ev[i].addr);
      tick();
      check($sformatf("err%0d_no_req", i), 32'(req_cnt - req0), 32'd0);
      check($sformatf("err%0d_no_wb", i),  32'(dv_cnt - dv0), 32'd0);
    end

    // Watchdog: grant withheld
    dv0 = dv_cnt;
    present(1'b1, 1'b0, cLw, 32'h0000_7000, 32'h0, 5'd5);
    tick();
    iAluValid = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (oErr === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check("wd_cycle",   32'(cyc), 32'd255);
    check("wd_erraddr", oErrAddr, 32'h0000_7000);
    check("wd_req",     32'(oMemReq), 32'd0);
    check("wd_stall",   32'(oStall), 32'd0);
    tick();
    check("wd_no_wb",   32'(dv_cnt - dv0), 32'd0);

    // Reset while in WAIT_RD, then a late rvalid
    dv0 = dv_cnt;
    present(1'b1, 1'b0, cLw, 32'h0000_8000, 32'h0, 5'd6);
    tick();
    iAluValid = 1'b0;
    iMemGnt = 1'b1;
    tick();
    iMemGnt = 1'b0;
    check("mid_wait_stall", 32'(oStall), 32'd1);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check("mid_rst_stall",   32'(oStall), 32'd0);
    check("mid_rst_req",     32'(oMemReq), 32'd0);
    check("mid_rst_we",      32'(oMemWe), 32'd0);
    check("mid_rst_be",      32'(oMemBe), 32'd0);
    check("mid_rst_addr",    oMemAddr, 32'd0);
    check("mid_rst_wdata",   oMemWData, 32'd0);
    check("mid_rst_regop",   32'(oRegOp), 32'd0);
    check("mid_rst_err",     32'(oErr), 32'd0);
    check("mid_rst_erraddr", oErrAddr, 32'd0);
    iMemRValid = 1'b1;
    iMemRData  = 32'h1111_2222;
    tick();
    iMemRValid = 1'b0;
    tick();
    check("late_rv_no_wb",  32'(dv_cnt - dv0), 32'd0);
    check("late_rv_data",   oRegOp.data, 32'd0);
    check("late_rv_stall",  32'(oStall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage sequencer for the core. It accepts one tAluOut per instruction from the execute stage and drives the data-memory request/grant/read-valid handshake for loads and stores. It aligns and extends load data and merges load results with pass-through ALU register writes into a single tRegOp writeback stream. It stalls upstream while a memory transaction is outstanding.

Parameters:
cTimeoutW, 8, width of the outstanding-transaction watchdog counter; timeout fires at 2**cTimeoutW-1 cycles.
cDataWidth, 32 (package), data width; the block supports 32 only.

Ports:
iClk  in  1  core clock
iRst  in  1  reset; synchronous, active-high
iAluValid  in  1  iAluOut is valid this cycle
iAluOut  in  tAluOut  memOp and regOp from the execute stage
oStall  out  1  upstream must hold; iAluValid is ignored while high
oMemReq  out  1  memory request, held until iMemGnt
oMemWe  out  1  1 = store, 0 = load
oMemAddr  out  32  word-aligned address (addr[1:0] forced to 0)
oMemWData  out  32  store data, lane-shifted
oMemBe  out  4  byte enables
iMemGnt  in  1  request accepted this cycle
iMemRValid  in  1  load data valid
iMemRData  in  32  load data (whole word)
oRegOp  out  tRegOp  writeback to the register file
oErr  out  1  one-cycle pulse on misaligned access, read&write both set, or timeout
oErrAddr  out  32  byte address of the faulting access, held until next error

Behaviour:
- Reset: state IDLE; oStall, oMemReq, oMemWe, oMemBe, oErr = 0; oMemAddr, oMemWData, oRegOp (dv, addr, data), oErrAddr = 0; watchdog = 0.
- States: IDLE, REQ, WAIT_RD.
- Acceptance (IDLE only) on iAluValid:
  - memOp.read = memOp.write = 0: register regOp to oRegOp next cycle (latency 1). Stay IDLE.
  - Exactly one of read/write set and aligned: capture the op. oMemReq = 1 from the next cycle. Go to REQ.
  - Both read and write set, or misaligned: pulse oErr next cycle, set oErrAddr, no memory access, no writeback, stay IDLE.
- Alignment by opType:
  - Byte ops (000, 100) are always aligned.
  - Halfword ops (001, 101) require addr[0] = 0.
  - Word (010) requires addr[1:0] = 0.
  - Opcodes 011, 110 and 111 are illegal and raise the error path.
- Stores:
  - Byte: oMemBe = 0001 << addr[1:0]; data[7:0] replicated to all four lanes.
  - Halfword: oMemBe = 0011 << addr[1:0]; data[15:0] replicated to both halves.
  - Word: oMemBe = 1111.
- REQ: hold oMemReq, oMemWe, oMemAddr, oMemBe, oMemWData stable until iMemGnt.
  - Store: on iMemGnt go to IDLE; no writeback.
  - Load: on iMemGnt go to WAIT_RD and drop oMemReq the following cycle.
- WAIT_RD: on iMemRValid, select the lane by addr[1:0] and extend:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - oRegOp = {dv = (rdAddr != 0), rdAddr, data} next cycle; return to IDLE.
- iMemRValid in the same cycle as iMemGnt while in REQ (zero-wait memory): take the data directly; writeback next cycle; skip WAIT_RD.
- oStall = (state != IDLE). Registered, so it rises the cycle after acceptance and falls in the cycle oRegOp.dv for the load is presented.
- oRegOp.dv is a one-cycle pulse per writeback. Its addr/data hold their last values when dv = 0.
- Watchdog: cleared on entering REQ and counts in REQ and WAIT_RD. At all-ones: pulse oErr, set oErrAddr, drop oMemReq, return to IDLE, no writeback.
- iMemRValid or iMemGnt outside the expected state is ignored.
- Reset mid-transaction returns to IDLE immediately with all outputs at reset values. A late iMemRValid after reset is ignored.

Decomposition:
- corePckg additions:
  - tMemState enum {eIdle, eReq, eWaitRd}.
  - opType constants cLb = 3'b000, cLh = 3'b001, cLw = 3'b010, cLbu = 3'b100, cLhu = 3'b101; the same encoding is used for stores.
  - tMemReq struct {req, we, addr, be, wdata}.
- One combinational sub-module, load_align_ext: inputs iMemRData, addr[1:0], opType; output is the 32-bit extended result. It is reused by the store lane logic's tests.

Test Plan:
- ALU-only op: regOp = {dv 1, addr 5, data 0x1234}, memOp read/write 0 -> oRegOp.dv = 1 with addr 5 and data 0x1234 one cycle later; oStall stays 0.
- SB at 0x1003, data 0x000000AB, gnt after 2 cycles -> oMemAddr 0x1000, oMemBe 1000, oMemWData 0xABABABAB held 3 cycles; no oRegOp.dv; oStall falls after gnt.
- LB at 0x2001, rd 7, rdata 0x0000_8000 -> oRegOp {1, 7, 0xFFFFFF80}. The same access as LBU -> 0x00000080. LH at 0x2002 with rdata 0x8001_0000 -> 0xFFFF8001.
- Zero-wait load: gnt and rvalid in the same cycle, LW 0x3000, rdata 0xDEADBEEF -> writeback 0xDEADBEEF two cycles after acceptance; WAIT_RD never entered.
- Errors: LW at 0x4002 -> oErr pulse, oErrAddr 0x4002, oMemReq never asserted. A load with gnt withheld for 255 cycles -> oErr pulse, return to IDLE, no writeback.
- Reset asserted in WAIT_RD, then rvalid arrives -> all outputs at reset values, no oRegOp.dv. LW to rd 0 -> transaction completes with dv = 0.
